// File: rtl/noc_pkg.sv
// Shared definitions for the NoC router output-port slice.
// Provides the default configuration constants, a helper for deriving
// VC id widths, the default flit / VC id types and the router port enum.
package noc_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_NUM_VC     = 2;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CREDITS    = 4;

  // A VC id is always at least one bit wide, even with a single VC.
  function automatic int vc_width(input int num_vc);
    return (num_vc <= 1) ? 1 : $clog2(num_vc);
  endfunction

  localparam int DEF_VC_W   = vc_width(DEF_NUM_VC);
  localparam int DEF_CRED_W = $clog2(DEF_CREDITS + 1);

  typedef logic [DEF_DATA_W-1:0] flit_t;
  typedef logic [DEF_VC_W-1:0]   vc_id_t;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-clock FIFO holding the flits of one virtual channel.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write din when not full
//   pop, dout       dout is the head; pop advances it when not empty
//   full, empty     occupancy flags from the registered count
//   count           number of stored flits
module noc_vc_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/noc_vc_output_port.sv
// Router output port with NUM_VC virtual channels.
// Flits from the crossbar are queued per VC; a round-robin arbiter picks one
// VC per cycle that has both a queued flit and a downstream credit, and the
// chosen flit is registered onto the link together with its VC id.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   data_i, vc_i    crossbar flit and its target VC
//   port_en         write strobe for data_i
//   inc_credit_i    per-VC credit return (multi-hot allowed)
//   full            per-VC FIFO full flags
//   data_o, vc_o    link flit and VC id, held when nothing is sent
//   send_data       link valid: high for exactly one cycle per flit
//   credit_o        packed per-VC credit counters, VC0 in the LSBs
//   err_o           sticky protocol error (bad write or credit overflow)
// Link handshake: there is no ready; a flit is transferred on every cycle
// send_data is high, and flow control is carried entirely by credits.
module noc_vc_output_port
  import noc_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_VC     = DEF_NUM_VC,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CREDITS    = DEF_CREDITS,
  localparam int VC_W      = vc_width(NUM_VC),
  localparam int CRED_W    = $clog2(CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_i,
  input  logic [VC_W-1:0]          vc_i,
  input  logic                     port_en,
  input  logic [NUM_VC-1:0]        inc_credit_i,
  output logic [NUM_VC-1:0]        full,
  output logic [DATA_W-1:0]        data_o,
  output logic [VC_W-1:0]          vc_o,
  output logic                     send_data,
  output logic [NUM_VC*CRED_W-1:0] credit_o,
  output logic                     err_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_VC-1:0] push, pop, fifo_full, fifo_empty, eligible;
  logic [CNT_W-1:0]  fifo_cnt [NUM_VC];
  logic [DATA_W-1:0] head     [NUM_VC];

  logic [CRED_W-1:0] credit_q [NUM_VC];
  logic [CRED_W-1:0] credit_d [NUM_VC];
  logic [VC_W-1:0]   rr_q, rr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic              send_q, send_d;
  logic              err_q, err_d;

  logic              vc_ok, wr_err, cr_err, grant_valid;
  logic [VC_W-1:0]   grant_vc, cand;

  for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_vc
    noc_vc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (push[gv]),
      .din   (data_i),
      .pop   (pop[gv]),
      .dout  (head[gv]),
      .full  (fifo_full[gv]),
      .empty (fifo_empty[gv]),
      .count (fifo_cnt[gv])
    );
  end

  // Write decode. A write toward a full VC is dropped even if that VC is
  // popped in the same cycle: the crossbar must never target a full VC.
  always_comb begin
    vc_ok  = (int'(vc_i) < NUM_VC);
    push   = '0;
    wr_err = port_en && !vc_ok;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]     = (fifo_cnt[v] == CNT_W'(FIFO_DEPTH));
      eligible[v] = !fifo_empty[v] && (credit_q[v] != '0);
      if (port_en && vc_ok && (vc_i == VC_W'(v))) begin
        if (fifo_full[v]) wr_err  = 1'b1;
        else              push[v] = 1'b1;
      end
    end
  end

  // Round-robin: scan upward from rr_q with wrap, first eligible VC wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_vc    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      cand = VC_W'((int'(rr_q) + i) % NUM_VC);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_vc    = cand;
      end
    end
    pop = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      pop[v] = grant_valid && (grant_vc == VC_W'(v));
    end
  end

  // Credits: a grant and a return on the same VC cancel out. A return that
  // would push a counter past CREDITS is ignored and flagged.
  always_comb begin
    cr_err = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      credit_d[v] = credit_q[v];
      if (inc_credit_i[v] && !pop[v]) begin
        if (credit_q[v] == CRED_W'(CREDITS)) cr_err      = 1'b1;
        else                                  credit_d[v] = credit_q[v] + 1'b1;
      end else if (pop[v] && !inc_credit_i[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end
      credit_o[v*CRED_W +: CRED_W] = credit_q[v];
    end
  end

  always_comb begin
    send_d = grant_valid;
    data_d = data_q;
    vc_d   = vc_q;
    rr_d   = rr_q;
    if (grant_valid) begin
      data_d = head[grant_vc];
      vc_d   = grant_vc;
      rr_d   = (int'(grant_vc) == NUM_VC - 1) ? '0 : grant_vc + 1'b1;
    end
    err_d = err_q | wr_err | cr_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q <= '{default: CRED_W'(CREDITS)};
      rr_q     <= '0;
      data_q   <= '0;
      vc_q     <= '0;
      send_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      rr_q     <= rr_d;
      data_q   <= data_d;
      vc_q     <= vc_d;
      send_q   <= send_d;
      err_q    <= err_d;
    end
  end

  assign data_o    = data_q;
  assign vc_o      = vc_q;
  assign send_data = send_q;
  assign err_o     = err_q;

endmodule

// File: doc/noc_vc_output_port.md
Name: noc_vc_output_port

Overview:
Parametrised next-generation router output port with NUM_VC virtual channels. It buffers flits from the crossbar in one FIFO per VC and tracks downstream buffer space with one credit counter per VC. Each cycle it picks one eligible VC round-robin and drives a single flit plus its VC id onto the link. One instance sits on each router output (N/E/S/W/L), between the crossbar and the neighbour's input port.

Parameters:
DATA_W, 16, flit width in bits
NUM_VC, 2, number of virtual channels (>=1)
FIFO_DEPTH, 4, local flit slots per VC (power of 2, >=2)
CREDITS, 4, downstream buffer slots per VC; the credit counter reset value
VC_W, $clog2(NUM_VC) (min 1), VC id width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
data_i  in  DATA_W  flit from crossbar
vc_i  in  VC_W  target VC of data_i
port_en  in  1  write data_i into FIFO[vc_i]
inc_credit_i  in  NUM_VC  one credit returned per set bit (one-hot or multi-hot)
full  out  NUM_VC  FIFO[v] holds FIFO_DEPTH flits
data_o  out  DATA_W  link flit
vc_o  out  VC_W  link VC id
send_data  out  1  link valid, one cycle per flit
credit_o  out  NUM_VC*$clog2(CREDITS+1)  per-VC credit counts, VC0 in LSBs
err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, async): all FIFOs empty; credits = CREDITS; rr pointer = 0; data_o=0, vc_o=0, send_data=0, full=0, err_o=0. Reset mid-transfer discards buffered flits. The link partner is reset together with this block.
- Write: on posedge with port_en=1 and full[vc_i]=0, push data_i into FIFO[vc_i].
  - Write while full[vc_i]=1: flit dropped, err_o set. This holds even if the same VC is popped in that cycle.
  - vc_i >= NUM_VC: write dropped, err_o set.
- Eligible VC v: FIFO[v] non-empty AND credit[v] > 0 (both from registered state).
- Arbitration: round-robin starting at rr pointer, searching upward with wrap. On a grant of v, rr pointer becomes (v+1) mod NUM_VC. With no grant the pointer holds.
- Send: on the edge that grants v, pop FIFO[v] and register data_o=head, vc_o=v, send_data=1. With no grant, send_data=0 and data_o/vc_o hold.
- Latency: a flit written at edge E into an empty FIFO with credit available appears on send_data after edge E+1. Throughput is 1 flit/cycle across all VCs combined.
- Credits: a grant of v decrements credit[v]; inc_credit_i[v] increments it.
  - Grant and increment on the same VC in one cycle: count unchanged.
  - Increment while credit[v]==CREDITS and no grant on v: ignored, err_o set.
- Credit==0 on a VC blocks only that VC; other VCs continue.
- full[v] is combinational from the registered FIFO count; the crossbar/route logic must not enable a write toward a full VC.
- err_o is sticky; only reset clears it.

Decomposition:
- Shared package noc_pkg: flit_t (logic [DATA_W-1:0]), vc_id_t, clog2-derived width constants, port enum {N,S,E,W,L}.
- Sub-module noc_vc_fifo: single-clock FIFO with push, pop, full, empty and count; instantiated NUM_VC times. Arbiter, credit counters and link register live in the top.

Test Plan:
- Reset, then write 0xA001 to VC0 at edge 1 -> send_data=1, data_o=0xA001, vc_o=0 after edge 2; credit[0]=3.
- Write 4 flits to VC0 and 4 to VC1 back-to-back, no credit return -> link order VC0,VC1,VC0,VC1…; credits reach 0/0; send_data then stays low; full deasserts as FIFOs drain.
- Credits exhausted, 2 flits still queued on VC1 -> pulse inc_credit_i=2'b10 once -> exactly one VC1 flit sent; VC0 traffic is unaffected throughout.
- Same cycle: grant on VC0 and inc_credit_i[0]=1 with credit[0]=2 -> credit[0] stays 2.
- Fill VC1 (4 flits, credit=0), write a 5th flit -> full[1]=1, flit dropped, err_o=1 stays set; a 6th write to VC0 is still accepted.
- Assert rst=0 asynchronously mid-burst -> outputs 0 immediately; after release, FIFOs are empty, credits=4/4, and the first grant goes to VC0.
